mem_arbiter: RTL and testbench

- Shares one single-port synchronous word RAM between the instruction-fetch port and the data (lw/sw) port of the CPU cores (multi_cycle_cpu, pipeline_cpu).
- Performs request/ack handshakes, fixed data priority with an anti-starvation override, alignment checking and word-index generation.
- Sits between the core's fetch/LSU logic and the unified memory instance.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one registered single-port word RAM between instruction fetch and data load/store.
// Data has fixed priority except when fetch has waited STARVE_LIMIT grants; every access takes 4 cycles.
module mem_arbiter #(
   parameter int MEM_DEPTH    = 1024,
   parameter int AW           = $clog2(MEM_DEPTH),
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic [31:0]   if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wdata,
   output logic [31:0]   d_rdata,
   output logic          d_ack,
   output logic          err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          busy
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   state_t        r_state;
   logic          r_ownerD;
   logic          r_misaligned;
   logic          r_isStore;
   logic [CW-1:0] r_starveCnt;
   logic          r_memEn;
   logic          r_memWe;
   logic [AW-1:0] r_memAddr;
   logic [31:0]   r_memWdata;
   logic [31:0]   r_ifRdata;
   logic [31:0]   r_dRdata;
   logic          r_ifAck;
   logic          r_dAck;
   logic          r_err;
   logic          r_busy;

   logic          w_starved;
   logic          w_grantD;
   logic [31:0]   w_selAddr;
   logic          w_misaligned;
   logic [31:0]   w_rdata;
   logic          w_unusedAddrBits;

   // Fetch wins a contended slot only once data has been granted STARVE_LIMIT times in a row.
   assign w_starved        = (r_starveCnt == CW'(STARVE_LIMIT));
   assign w_grantD         = d_req && !(if_req && w_starved);
   assign w_selAddr        = w_grantD ? d_addr : if_addr;
   assign w_misaligned     = |w_selAddr[1:0];
   assign w_rdata          = (r_misaligned || r_isStore) ? 32'h0 : mem_rdata;
   assign w_unusedAddrBits = ^w_selAddr[31:AW+2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_ownerD     <= 1'b0;
         r_misaligned <= 1'b0;
         r_isStore    <= 1'b0;
         r_starveCnt  <= '0;
         r_memEn      <= 1'b0;
         r_memWe      <= 1'b0;
         r_memAddr    <= '0;
         r_memWdata   <= 32'h0;
         r_ifRdata    <= 32'h0;
         r_dRdata     <= 32'h0;
         r_ifAck      <= 1'b0;
         r_dAck       <= 1'b0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (if_req && w_grantD)
                  r_starveCnt <= w_starved ? r_starveCnt : r_starveCnt + CW'(1);
               else
                  r_starveCnt <= '0;
               if (if_req || d_req) begin
                  r_ownerD     <= w_grantD;
                  r_isStore    <= w_grantD && d_we;
                  r_misaligned <= w_misaligned;
                  r_memAddr    <= w_selAddr[AW+1:2];
                  r_memWdata   <= d_wdata;
                  r_memEn      <= !w_misaligned;
                  r_memWe      <= w_grantD && d_we && !w_misaligned;
                  r_busy       <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_memEn <= 1'b0;
               r_memWe <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_ownerD) begin
                  r_dRdata <= w_rdata;
                  r_dAck   <= 1'b1;
               end else begin
                  r_ifRdata <= w_rdata;
                  r_ifAck   <= 1'b1;
               end
               r_err   <= r_misaligned;
               r_state <= S_ACK;
            end
            S_ACK: begin
               r_ifAck <= 1'b0;
               r_dAck  <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_rdata  = r_ifRdata;
   assign if_ack    = r_ifAck;
   assign d_rdata   = r_dRdata;
   assign d_ack     = r_dAck;
   assign err       = r_err;
   assign mem_en    = r_memEn;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven single accesses, contention, reset mid-access.
// Expected ack records sit in a scoreboard queue that a negedge monitor pops.
module tb_mem_arbiter;

   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic          if_req;
   logic [31:0]   if_addr;
   logic [31:0]   if_rdata;
   logic          if_ack;
   logic          d_req;
   logic          d_we;
   logic [31:0]   d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_ack;
   logic          err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          busy;

   typedef struct {
      logic          isD;
      logic          we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic          expEn;
      logic          expWe;
      logic [AW-1:0] expMemAddr;
      logic [31:0]   expRdata;
      logic          expErr;
   } vec_t;

   typedef struct {
      logic        isD;
      logic [31:0] rdata;
      logic        err;
   } sb_t;

   vec_t        vecs[9];
   sb_t         sbQueue[$];
   sb_t         monExp;
   int          checkCount = 0;
   int          passCount  = 0;
   int          ackSeen    = 0;

   logic [31:0]   ram [0:1023];
   logic          ldEn;
   logic [AW-1:0] ldAddr;
   logic [31:0]   ldData;

   mem_arbiter #(.MEM_DEPTH(1024), .STARVE_LIMIT(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .err       (err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered single-port RAM; ldEn is a bench-only backdoor used while reset is held.
   always @(posedge clk) begin
      if (ldEn) begin
         ram[ldAddr] <= ldData;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (reset && (if_ack || d_ack)) begin
         ackSeen++;
         checkOutput("ackExclusive", 64'(if_ack && d_ack), 64'(0));
         checkOutput("sbNonEmpty", 64'(sbQueue.size() != 0), 64'(1));
         if (sbQueue.size() != 0) begin
            monExp = sbQueue.pop_front();
            checkOutput("grantPort", 64'(d_ack), 64'(monExp.isD));
            checkOutput("ackRdata", 64'(monExp.isD ? d_rdata : if_rdata), 64'(monExp.rdata));
            checkOutput("ackErr", 64'(err), 64'(monExp.err));
         end
      end
   end

   task automatic loadWord(input logic [AW-1:0] a, input logic [31:0] data);
      @(negedge clk);
      ldEn   = 1'b1;
      ldAddr = a;
      ldData = data;
      @(negedge clk);
      ldEn   = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] otherBefore;
      int          lat;
      otherBefore = v.isD ? if_rdata : d_rdata;
      sbQueue.push_back('{v.isD, v.expRdata, v.expErr});
      if (v.isD) begin
         d_req   = 1'b1;
         d_we    = v.we;
         d_addr  = v.addr;
         d_wdata = v.wdata;
      end else begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end
      @(posedge clk);
      #1;
      checkOutput("issueMemEn", 64'(mem_en), 64'(v.expEn));
      checkOutput("issueMemWe", 64'(mem_we), 64'(v.expWe));
      checkOutput("issueBusy", 64'(busy), 64'(1));
      if (v.expEn) checkOutput("issueMemAddr", 64'(mem_addr), 64'(v.expMemAddr));
      if (v.expWe) checkOutput("issueMemWdata", 64'(mem_wdata), 64'(v.wdata));
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clk);
         #1;
         if (v.isD ? d_ack : if_ack) lat = k;
         else if (k == 2) checkOutput("memEnOneCycle", 64'({mem_en, mem_we}), 64'(0));
      end
      checkOutput("ackLatency", 64'(lat), 64'(3));
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      checkOutput("otherRdataHold", 64'(v.isD ? if_rdata : d_rdata), 64'(otherBefore));
      @(negedge clk);
      #1;
      checkOutput("busyClear", 64'(busy), 64'(0));
   endtask

   task automatic runContention();
      int startSeen;
      for (int i = 0; i < 6; i++) begin
         if (i == 2 || i == 5) sbQueue.push_back('{1'b0, 32'h2010000A, 1'b0});
         else                  sbQueue.push_back('{1'b1, 32'h00001234, 1'b0});
      end
      if_addr   = 32'h0C;
      d_addr    = 32'h40;
      d_we      = 1'b0;
      d_wdata   = 32'h0;
      startSeen = ackSeen;
      if_req    = 1'b1;
      d_req     = 1'b1;
      for (int k = 0; k < 80 && (ackSeen - startSeen) < 6; k++) begin
         @(negedge clk);
         #1;
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      checkOutput("contentionAcks", 64'(ackSeen - startSeen), 64'(6));
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic runResetMidOp();
      int startSeen;
      startSeen = ackSeen;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h40;
      d_wdata = 32'h77;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("midOpBusy", 64'(busy), 64'(1));
      reset = 1'b0;
      #1;
      checkOutput("rstCtrl", 64'({mem_en, mem_we, if_ack, d_ack, err, busy}), 64'(0));
      checkOutput("rstMemAddr", 64'(mem_addr), 64'(0));
      checkOutput("rstMemWdata", 64'(mem_wdata), 64'(0));
      checkOutput("rstRdata", 64'({if_rdata, d_rdata}), 64'(0));
      @(negedge clk);
      d_req = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      repeat (4) @(negedge clk);
      #1;
      checkOutput("noAckAfterReset", 64'(ackSeen - startSeen), 64'(0));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset   = 1'b0;
      if_req  = 1'b0;
      if_addr = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
      ldEn    = 1'b0;
      ldAddr  = '0;
      ldData  = 32'h0;

      vecs[0] = '{1'b0, 1'b0, 32'h0000000C, 32'h0,        1'b1, 1'b0, 10'd3,   32'h2010000A, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h00000040, 32'h1234,     1'b1, 1'b1, 10'd16,  32'h0,        1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h00000040, 32'h5555,     1'b1, 1'b0, 10'd16,  32'h00001234, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h00000042, 32'hDEAD,     1'b0, 1'b0, 10'd16,  32'h0,        1'b1};
      vecs[4] = '{1'b1, 1'b0, 32'h00000040, 32'h0,        1'b1, 1'b0, 10'd16,  32'h00001234, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 32'h00001004, 32'h0,        1'b1, 1'b0, 10'd1,   32'hCAFEF00D, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 32'h0000000E, 32'h0,        1'b0, 1'b0, 10'd3,   32'h0,        1'b1};
      vecs[7] = '{1'b1, 1'b1, 32'h000013FC, 32'hA5A5A5A5, 1'b1, 1'b1, 10'd255, 32'h0,        1'b0};
      vecs[8] = '{1'b1, 1'b0, 32'h000003FC, 32'h0,        1'b1, 1'b0, 10'd255, 32'hA5A5A5A5, 1'b0};

      loadWord(10'd3, 32'h2010000A);
      loadWord(10'd1, 32'hCAFEF00D);
      @(negedge clk);
      #1;
      checkOutput("resetCtrl", 64'({mem_en, mem_we, if_ack, d_ack, err, busy}), 64'(0));
      checkOutput("resetMemAddr", 64'(mem_addr), 64'(0));
      checkOutput("resetMemWdata", 64'(mem_wdata), 64'(0));
      checkOutput("resetIfRdata", 64'(if_rdata), 64'(0));
      checkOutput("resetDRdata", 64'(d_rdata), 64'(0));

      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

      runContention();
      runResetMidOp();
      applyStimulus(vecs[4]);

      repeat (4) @(negedge clk);
      checkOutput("sbDrained", 64'(sbQueue.size()), 64'(0));
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
